// File: rtl/proj_sched_pkg.sv
// proj_sched_pkg: shared offsets, FSM encoding and STATUS layout for the project scheduler
package proj_sched_pkg;
  localparam logic [3:0] OFS_TARGET = 4'h0;
  localparam logic [3:0] OFS_STATUS = 4'h4;
  localparam logic [3:0] OFS_CTRL   = 4'h8;
  localparam logic [3:0] OFS_DWELL  = 4'hC;
  typedef enum logic [1:0] {ST_RUN = 2'd0, ST_DRAIN = 2'd1, ST_RESET = 2'd2} state_t;
  localparam int STB_BUSY = 8;
  localparam int STB_ROT  = 9;
  localparam int STB_ERR  = 10;
  localparam int STB_PEND = 11;
endpackage

// File: rtl/sched_wb_regs.sv
// sched_wb_regs: wishbone decode, register storage and one-deep pending target slot
module sched_wb_regs import proj_sched_pkg::*; #(
  parameter logic [31:0] BASE_ADDR = 32'h30000000,
  parameter int NUM_PROJECTS = 5
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  input  logic [7:0]  i_active,
  input  logic        i_busy,
  input  logic        i_take,
  output logic        o_tgt_wr,
  output logic [7:0]  o_tgt,
  output logic        o_pend_v,
  output logic [7:0]  o_pend,
  output logic        o_rot_en,
  output logic [31:0] o_dwell,
  output logic        o_dwell_wr
);
  localparam logic [8:0] NUMP = 9'(NUM_PROJECTS);
  logic        r_ack, r_tgt_wr, r_pv, r_rot, r_err;
  logic [31:0] r_dat, r_dwell, w_status, w_rdata;
  logic [7:0]  r_tgt, r_pend;
  logic        w_hit, w_wr, w_rd, w_tsel, w_csel, w_tok;
  logic [3:0]  w_ofs;
  assign w_ofs  = wbs_adr_i[3:0];
  assign w_hit  = wbs_cyc_i && wbs_stb_i && !r_ack && wbs_adr_i[31:4] == BASE_ADDR[31:4];
  assign w_wr   = w_hit && wbs_we_i && |wbs_sel_i;
  assign w_rd   = w_hit && !wbs_we_i;
  assign w_tsel = w_wr && w_ofs == OFS_TARGET;
  assign w_csel = w_wr && w_ofs == OFS_CTRL;
  assign w_tok  = {1'b0, wbs_dat_i[7:0]} < NUMP;
  assign o_dwell_wr = w_wr && w_ofs == OFS_DWELL;
  always_comb begin
    w_status = 32'd0;
    w_status[7:0] = i_active;
    w_status[STB_BUSY] = i_busy;
    w_status[STB_ROT]  = r_rot;
    w_status[STB_ERR]  = r_err;
    w_status[STB_PEND] = r_pv;
    w_rdata = w_ofs == OFS_STATUS ? w_status : w_ofs == OFS_DWELL ? r_dwell : 32'd0;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ack <= 1'b0;
      r_dat <= 32'd0;
      r_tgt_wr <= 1'b0;
      r_tgt <= 8'd0;
      r_pv <= 1'b0;
      r_pend <= 8'd0;
      r_rot <= 1'b0;
      r_err <= 1'b0;
      r_dwell <= 32'd0;
    end else begin
      r_ack <= w_hit;
      r_dat <= w_rd ? w_rdata : 32'd0;
      r_tgt_wr <= w_tsel && w_tok;
      if (w_tsel) r_tgt <= wbs_dat_i[7:0];
      if (w_tsel && !w_tok) r_err <= 1'b1;
      else if (w_csel && wbs_dat_i[1]) r_err <= 1'b0;
      if (w_csel) r_rot <= wbs_dat_i[0];
      if (o_dwell_wr) r_dwell <= wbs_dat_i;
      // a write landing mid-switch parks here; the FSM consumes it on its first RUN cycle
      if (r_tgt_wr && i_busy) begin
        r_pv <= 1'b1;
        r_pend <= r_tgt;
      end else if (i_take) r_pv <= 1'b0;
    end
  end
  assign wbs_ack_o = r_ack;
  assign wbs_dat_o = r_dat;
  assign o_tgt_wr  = r_tgt_wr;
  assign o_tgt     = r_tgt;
  assign o_pend_v  = r_pv;
  assign o_pend    = r_pend;
  assign o_rot_en  = r_rot;
  assign o_dwell   = r_dwell;
endmodule

// File: rtl/project_sched_ctrl.sv
// project_sched_ctrl: safe active-project switch sequencer with optional dwell-timed rotation
module project_sched_ctrl import proj_sched_pkg::*; #(
  parameter logic [31:0] BASE_ADDR = 32'h30000000,
  parameter int NUM_PROJECTS = 5,
  parameter int HOLD_CYCLES = 4,
  parameter int RESET_CYCLES = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    wbs_stb_i,
  input  logic                    wbs_cyc_i,
  input  logic                    wbs_we_i,
  input  logic [3:0]              wbs_sel_i,
  input  logic [31:0]             wbs_adr_i,
  input  logic [31:0]             wbs_dat_i,
  output logic                    wbs_ack_o,
  output logic [31:0]             wbs_dat_o,
  output logic [7:0]              active_project,
  output logic [NUM_PROJECTS-1:0] proj_reset,
  output logic                    io_hold,
  output logic                    busy,
  output logic                    switch_done
);
  localparam logic [15:0] HOLD_M1 = 16'(HOLD_CYCLES - 1);
  localparam logic [15:0] RST_M1  = 16'(RESET_CYCLES - 1);
  localparam logic [7:0]  LAST    = 8'(NUM_PROJECTS - 1);
  state_t      r_state, w_state;
  logic [15:0] r_ph, w_ph;
  logic [31:0] r_dw, w_dw, w_dwell;
  logic [7:0]  r_act, w_act, r_tgt, w_tgt, w_tgt_dat, w_pend_dat, w_req_tgt;
  logic        r_done, w_done, w_tgt_wr, w_pend_v, w_rot_en, w_dwell_wr;
  logic        w_run, w_cnt, w_tick, w_req;
  sched_wb_regs #(.BASE_ADDR(BASE_ADDR), .NUM_PROJECTS(NUM_PROJECTS)) u_regs (
    .clk(clk), .reset_n(reset_n),
    .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .i_active(r_act), .i_busy(!w_run), .i_take(w_run && w_pend_v),
    .o_tgt_wr(w_tgt_wr), .o_tgt(w_tgt_dat), .o_pend_v(w_pend_v), .o_pend(w_pend_dat),
    .o_rot_en(w_rot_en), .o_dwell(w_dwell), .o_dwell_wr(w_dwell_wr)
  );
  assign w_run  = r_state == ST_RUN;
  assign w_cnt  = w_run && !w_pend_v && w_rot_en && w_dwell != 32'd0;
  assign w_tick = w_cnt && r_dw == w_dwell - 32'd1;
  assign w_req  = w_run && (w_tgt_wr || w_pend_v || w_tick);
  // a fresh write beats the parked one, which beats the rotate tick
  assign w_req_tgt = w_tgt_wr ? w_tgt_dat : w_pend_v ? w_pend_dat : r_act == LAST ? 8'd0 : r_act + 8'd1;
  always_comb begin
    w_state = r_state;
    w_ph = w_run ? 16'd0 : r_ph + 16'd1;
    w_act = r_act;
    w_tgt = r_tgt;
    w_done = 1'b0;
    w_dw = w_cnt && !w_tick && !w_dwell_wr ? r_dw + 32'd1 : 32'd0;
    case (r_state)
      ST_RUN: if (w_req && w_req_tgt != r_act) begin
        w_state = ST_DRAIN;
        w_tgt = w_req_tgt;
      end
      ST_DRAIN: if (r_ph == HOLD_M1) begin
        w_state = ST_RESET;
        w_ph = 16'd0;
        w_act = r_tgt;
      end
      ST_RESET: if (r_ph == RST_M1) begin
        w_state = ST_RUN;
        w_done = 1'b1;
      end
      default: w_state = ST_RUN;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_RUN;
      r_ph <= 16'd0;
      r_dw <= 32'd0;
      r_act <= 8'd0;
      r_tgt <= 8'd0;
      r_done <= 1'b0;
    end else begin
      r_state <= w_state;
      r_ph <= w_ph;
      r_dw <= w_dw;
      r_act <= w_act;
      r_tgt <= w_tgt;
      r_done <= w_done;
    end
  end
  assign active_project = r_act;
  assign io_hold = !w_run;
  assign busy = !w_run;
  assign switch_done = r_done;
  assign proj_reset = w_run ? ~(NUM_PROJECTS'(1) << r_act) : '1;
endmodule

// File: doc/project_sched_ctrl.md
Name: project_sched_ctrl

Overview:
Wishbone-configured sequencer that owns the active-project selection for the multi-project harness. Switches between projects safely: quiesce the pads, pulse the incoming project's reset, then hand over the pads. Optional auto-rotate mode cycles through the projects on a programmable dwell time. Holds every non-selected project in reset, and its outputs drive the harness IO mux select and the per-project reset lines.

Parameters:
BASE_ADDR, 32'h30000000, base of the 16-byte register window
NUM_PROJECTS, 5, number of selectable projects (1..255)
HOLD_CYCLES, 4, cycles the pads stay quiesced before the new project's reset is released (>=1)
RESET_CYCLES, 8, cycles the incoming project's reset is asserted (>=1)

Ports:
clk  input  1  system clock (wb_clk_i)
reset_n  input  1  asynchronous active-low reset
wbs_stb_i  input  1  wishbone strobe
wbs_cyc_i  input  1  wishbone cycle
wbs_we_i  input  1  write enable
wbs_sel_i  input  4  byte selects
wbs_adr_i  input  32  address
wbs_dat_i  input  32  write data
wbs_ack_o  output  1  ack, single-cycle pulse
wbs_dat_o  output  32  read data, valid with ack, else 0
active_project  output  8  IO mux select
proj_reset  output  NUM_PROJECTS  per-project active-high reset
io_hold  output  1  1 = harness forces io_out=0 and io_oeb all-input
busy  output  1  switch sequence in progress
switch_done  output  1  one-cycle pulse when a new project enters RUN

Behaviour:
- Reset values while reset_n low:
  - active_project=0, io_hold=0, busy=0, switch_done=0
  - proj_reset = all ones except bit 0
  - wbs_ack_o=0, wbs_dat_o=0
  - rotate_en=0, dwell=0, err=0, no pending request
  - FSM=RUN
- Registers, offsets from BASE_ADDR:
  - 0x0 TARGET (W): [7:0] requested project.
  - 0x4 STATUS (R): [7:0] active_project, [8] busy, [9] rotate_en, [10] err sticky, [11] pending.
  - 0x8 CTRL (W): [0] rotate_en, [1] write-1-clear err.
  - 0xC DWELL (R/W): 32-bit rotate period in cycles.
- Wishbone handshake:
  - A valid request is cyc&stb. Write = we with sel nonzero; read = we=0.
  - Any valid request in the window gets ack exactly one cycle later. The ack is a pulse: ack is never asserted in two consecutive cycles, so a held request is re-acked only after a gap cycle.
  - Writes ignore sel granularity: sel nonzero writes the full register.
  - Out-of-window addresses get no ack. Unmapped in-window reads return 0. Reads of write-only registers return 0.
- FSM states: RUN, DRAIN, RESET.
  - RUN: io_hold=0. Only proj_reset[active_project]=0.
  - Switch request in RUN (TARGET write or rotate tick):
    - Target equal to active: no-op, no switch_done.
    - Valid new target: go to DRAIN with busy=1, io_hold=1.
  - DRAIN: lasts HOLD_CYCLES cycles. Old project's reset asserts on DRAIN entry. On exit, active_project <= target, then go to RESET.
  - RESET: all proj_reset asserted, io_hold=1, for RESET_CYCLES cycles. Then RUN: clear the target's reset bit, io_hold=0, busy=0, switch_done pulse in that same cycle.
- Latency: TARGET write ack to io_hold=0 is exactly 1+HOLD_CYCLES+RESET_CYCLES cycles.
- Target >= NUM_PROJECTS: request ignored, err set, ack still given.
- TARGET write while busy: stored in a one-deep pending slot (last write wins), serviced on the first RUN cycle after the current switch. Rotate ticks while busy are dropped.
- Rotate:
  - Active when rotate_en=1 and DWELL!=0.
  - A dwell counter runs only in RUN without a pending request. At count DWELL-1 it issues a switch to (active_project+1) mod NUM_PROJECTS and clears.
  - Clearing rotate_en, or writing DWELL, zeroes the counter.
- Simultaneous TARGET write and rotate tick in the same cycle: the TARGET write wins, and the tick is discarded.
- reset_n assertion mid-sequence returns all state to reset values immediately (asynchronous).
- NUM_PROJECTS=1: every switch is a no-op, and rotate never leaves project 0.

Decomposition:
- Shared package proj_sched_pkg:
  - register offsets (OFS_TARGET/STATUS/CTRL/DWELL)
  - FSM state encoding (2 bits)
  - STATUS bit positions
- One natural sub-module, sched_wb_regs: wishbone decode, ack/readback, register storage, pending slot.
- The FSM and dwell counter stay in the top module.

Test Plan:
- Reset release, then read STATUS -> ack after 1 cycle, data 0x000; proj_reset=5'b11110; io_hold=0.
- Write TARGET=3 -> io_hold=1 for 4+8 cycles; active_project=3 after 4 cycles; switch_done pulse 13 cycles after ack; proj_reset=5'b10111.
- Write TARGET=7 -> ack, no state change, STATUS[10]=1. Then write CTRL=0x2 -> STATUS[10]=0.
- During switch to 1, write TARGET=2 then TARGET=4 -> STATUS[11]=1; after 1 completes, second switch runs to 4 (not 2).
- DWELL=20, CTRL=1 from project 4 -> switch to 0 begins 20 cycles after CTRL write; next dwell starts only after switch_done.
- Deassert reset_n in DRAIN -> immediately active_project=0, io_hold=0, busy=0, proj_reset=5'b11110.
